// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the Sobel frame-memory driver:
//   - default image geometry and pixel width
//   - window width (nine pixels of a 3x3 neighbourhood)
//   - frame transaction counts (pixels written, windows read)
//   - the driver state enumeration
//   - helper for sizing the transaction counters
// -----------------------------------------------------------------------------
package sobel_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int PIX_W_DEF = 8;

  localparam int WIN_W = 9 * PIX_W_DEF;

  localparam int FRAME_PIX = IMG_W_DEF * IMG_H_DEF;
  localparam int FRAME_WIN = (IMG_W_DEF - 2) * (IMG_H_DEF - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_STB,
    ST_RD_SETUP,
    ST_RD_STB,
    ST_RD_CAP,
    ST_RD_OUT,
    ST_DONE
  } drv_state_t;

  // Both counters share one width, big enough to hold a full pixel count.
  function automatic int cntWidth(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

endpackage

// File: rtl/sobel_drv_cnt.sv
// -----------------------------------------------------------------------------
// sobel_drv_cnt
// Terminal-count transaction counter. Counts increments since the last clear
// and flags when the next increment is the final one of the frame.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous reset, active-low
//   i_clear  synchronous clear to zero (frame start)
//   i_inc    count one transaction
//   o_last   current count equals TERMINAL-1, so this increment completes it
// -----------------------------------------------------------------------------
module sobel_drv_cnt #(
  parameter int WIDTH    = 19,
  parameter int TERMINAL = 307200
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_last
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Compare against TERMINAL-1 so the FSM can branch in the same cycle it
  // issues the final increment.
  assign o_last = (r_count == WIDTH'(TERMINAL - 1));

endmodule

// File: rtl/sobel_mem_driver.sv
// -----------------------------------------------------------------------------
// sobel_mem_driver
// Sole master of the Sobel frame-memory byte bus. Writes one raster frame
// into memory, then reads back every valid 3x3 window and hands each one to
// the Sobel kernel over a valid/ready interface. The memory tracks its own
// row/column pointers, so the driver only counts transactions.
// Ports:
//   i_clk, i_reset       clock (rising edge), async active-low reset
//   i_start              one-cycle frame start, honoured in IDLE or DONE only
//   i_pix_in_*           raster pixel stream in (valid/ready)
//   o_bus_wdata          memory write data
//   i_bus_rdata          3x3 window returned by the memory
//   o_bus_strobe_n       transaction strobe, active-low, one cycle wide
//   o_bus_rw             1 = read, 0 = write; only changes with strobe high
//   o_win_data/_valid    captured window out, column-major, top-left in MSBs
//   i_win_ready          downstream accepts window
//   o_busy, o_done       frame in progress / frame complete (held till start)
// Optional macro SOBEL_DRV_COORD_EN adds o_win_row / o_win_col, the top-left
// coordinate of the window currently on o_win_data.
// -----------------------------------------------------------------------------
module sobel_mem_driver
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [PIX_W-1:0]         i_pix_in_data,
  input  logic                     i_pix_in_valid,
  output logic                     o_pix_in_ready,
  output logic [PIX_W-1:0]         o_bus_wdata,
  input  logic [9*PIX_W-1:0]       i_bus_rdata,
  output logic                     o_bus_strobe_n,
  output logic                     o_bus_rw,
  output logic [9*PIX_W-1:0]       o_win_data,
  output logic                     o_win_valid,
  input  logic                     i_win_ready,
`ifdef SOBEL_DRV_COORD_EN
  output logic [$clog2(IMG_H)-1:0] o_win_row,
  output logic [$clog2(IMG_W)-1:0] o_win_col,
`endif
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int CNT_W   = cntWidth(IMG_W, IMG_H);
  localparam int N_PIX   = IMG_W * IMG_H;
  localparam int N_WIN   = (IMG_W - 2) * (IMG_H - 2);

  drv_state_t         r_state;
  drv_state_t         w_nextState;
  logic [PIX_W-1:0]   r_wdata;
  logic [9*PIX_W-1:0] r_winData;

  logic w_clear;
  logic w_wrInc;
  logic w_rdInc;
  logic w_loadPix;
  logic w_capture;
  logic w_wrLast;
  logic w_rdLast;

  logic w_ready;
  logic w_strobeN;
  logic w_rw;
  logic w_valid;
  logic w_busy;
  logic w_done;

  sobel_drv_cnt #(
    .WIDTH    (CNT_W),
    .TERMINAL (N_PIX)
  ) u_wrCnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .i_inc   (w_wrInc),
    .o_last  (w_wrLast)
  );

  sobel_drv_cnt #(
    .WIDTH    (CNT_W),
    .TERMINAL (N_WIN)
  ) u_rdCnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .i_inc   (w_rdInc),
    .o_last  (w_rdLast)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Bus outputs are decoded purely from the state register, so strobe and
  // rw move on clock edges only. rw is raised on entry to RD_SETUP, a
  // strobe-high state, and dropped on entry to DONE, also strobe-high.
  always_comb begin
    w_nextState = r_state;
    w_clear     = 1'b0;
    w_wrInc     = 1'b0;
    w_rdInc     = 1'b0;
    w_loadPix   = 1'b0;
    w_capture   = 1'b0;
    w_ready     = 1'b0;
    w_strobeN   = 1'b1;
    w_rw        = 1'b0;
    w_valid     = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_clear     = 1'b1;
          w_nextState = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        w_ready = 1'b1;
        if (i_pix_in_valid) begin
          w_loadPix   = 1'b1;
          w_nextState = ST_WR_STB;
        end
      end
      ST_WR_STB: begin
        w_strobeN   = 1'b0;
        w_wrInc     = 1'b1;
        w_nextState = w_wrLast ? ST_RD_SETUP : ST_WR_REQ;
      end
      ST_RD_SETUP: begin
        w_rw        = 1'b1;
        w_nextState = ST_RD_STB;
      end
      ST_RD_STB: begin
        w_strobeN   = 1'b0;
        w_rw        = 1'b1;
        w_nextState = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        w_rw        = 1'b1;
        w_capture   = 1'b1;
        w_nextState = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        w_rw    = 1'b1;
        w_valid = 1'b1;
        if (i_win_ready) begin
          w_rdInc     = 1'b1;
          w_nextState = w_rdLast ? ST_DONE : ST_RD_STB;
        end
      end
      ST_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        if (i_start) begin
          w_clear     = 1'b1;
          w_nextState = ST_WR_REQ;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Write data is held from acceptance through the following strobe cycle;
  // the window is held from RD_CAP until the next capture.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wdata   <= '0;
      r_winData <= '0;
    end else begin
      if (w_loadPix) begin
        r_wdata <= i_pix_in_data;
      end
      if (w_capture) begin
        r_winData <= i_bus_rdata;
      end
    end
  end

`ifdef SOBEL_DRV_COORD_EN
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  // Coordinates follow the memory's window order: column first, wrapping to
  // the next row after the last valid column IMG_W-3.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_rdInc) begin
      if (r_col == COL_W'(IMG_W - 3)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign o_win_row = r_row;
  assign o_win_col = r_col;
`endif

  assign o_pix_in_ready = w_ready;
  assign o_bus_wdata    = r_wdata;
  assign o_bus_strobe_n = w_strobeN;
  assign o_bus_rw       = w_rw;
  assign o_win_data     = r_winData;
  assign o_win_valid    = w_valid;
  assign o_busy         = w_busy;
  assign o_done         = w_done;

endmodule

// File: tb/tb_sobel_mem_driver.sv
// -----------------------------------------------------------------------------
// tb_sobel_mem_driver
// Directed bench for sobel_mem_driver on a 4x3 frame. A bus monitor acts as
// the frame memory: it stores written pixels and answers each read strobe
// with the 3x3 window the memory would return. Windows are compared against
// hand-computed constants. Define SOBEL_DRV_COORD_EN to also check coords.
// -----------------------------------------------------------------------------
module tb_sobel_mem_driver;

  localparam int IW = 4;
  localparam int IH = 3;
  localparam int PW = 8;
  localparam int WW = 9 * PW;

  localparam logic [71:0] W0 = 72'h010509_02060a_03070b;
  localparam logic [71:0] W1 = 72'h02060a_03070b_04080c;

  logic          clk = 1'b0;
  logic          resetN;
  logic          start;
  logic [PW-1:0] pixData;
  logic          pixValid;
  logic          pixReady;
  logic [PW-1:0] busWdata;
  logic [WW-1:0] busRdata;
  logic          strobeN;
  logic          busRw;
  logic [WW-1:0] winData;
  logic          winValid;
  logic          winReady;
  logic          busy;
  logic          done;
`ifdef SOBEL_DRV_COORD_EN
  logic [1:0]    winRow;
  logic [1:0]    winCol;
`endif

  always #5 clk = ~clk;

  sobel_mem_driver #(
    .IMG_W (IW),
    .IMG_H (IH),
    .PIX_W (PW)
  ) dut (
    .i_clk          (clk),
    .i_reset        (resetN),
    .i_start        (start),
    .i_pix_in_data  (pixData),
    .i_pix_in_valid (pixValid),
    .o_pix_in_ready (pixReady),
    .o_bus_wdata    (busWdata),
    .i_bus_rdata    (busRdata),
    .o_bus_strobe_n (strobeN),
    .o_bus_rw       (busRw),
    .o_win_data     (winData),
    .o_win_valid    (winValid),
    .i_win_ready    (winReady),
`ifdef SOBEL_DRV_COORD_EN
    .o_win_row      (winRow),
    .o_win_col      (winCol),
`endif
    .o_busy         (busy),
    .o_done         (done)
  );

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string tag, input logic [71:0] observed,
                             input logic [71:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Memory model: records writes, answers reads with the window at the
  // memory's own raster window pointer.
  int            wrStrobes = 0;
  int            rdStrobes = 0;
  int            frameBase = 0;
  int            rdBase    = 0;
  logic [PW-1:0] mem [0:IW*IH-1];
  logic          prevStrobeN = 1'b1;
  logic          prevAccept  = 1'b0;

  always @(negedge clk) begin
    int idx;
    int row;
    int col;
    logic [71:0] w;
    if (strobeN === 1'b0) begin
      checkOutput("strobe_gap", 72'(prevStrobeN), 72'(1));
      if (busRw === 1'b0) begin
        checkOutput("wr_after_accept", 72'(prevAccept), 72'(1));
        idx = wrStrobes - frameBase;
        if (idx >= 0 && idx < IW*IH) mem[idx] = busWdata;
        wrStrobes++;
      end else begin
        idx = rdStrobes - rdBase;
        row = idx / (IW - 2);
        col = idx % (IW - 2);
        w = '0;
        for (int c = 0; c < 3; c++) begin
          for (int r = 0; r < 3; r++) begin
            if ((row + r) < IH) w = (w << 8) | 72'(mem[(row + r) * IW + col + c]);
          end
        end
        busRdata = w;
        rdStrobes++;
      end
    end
    prevStrobeN = strobeN;
    prevAccept  = pixReady & pixValid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulseStart();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Pixel source: sends n pixels 0x01.. in order; stall toggles valid.
  task automatic applyStimulus(input bit stall, input int n, output int cycles);
    int  sent = 0;
    int  cyc  = 0;
    bit  acc;
    pixData  = 8'd1;
    pixValid = 1'b1;
    while (sent < n && cyc < 200) begin
      @(negedge clk);
      acc = pixReady & pixValid;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        pixData = PW'(sent + 1);
      end
      pixValid = stall ? (cyc % 3 != 1) : 1'b1;
    end
    pixValid = 1'b0;
    cycles = cyc;
    checkOutput("src_sent", 72'(sent), 72'(n));
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (winValid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput(tag, 72'(winValid), 72'(1));
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, 72'(done), 72'(1));
  endtask

  initial begin
    int cycles;
    int n;
    resetN   = 1'b0;
    start    = 1'b0;
    pixData  = '0;
    pixValid = 1'b0;
    busRdata = '0;
    winReady = 1'b1;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_strobe_n", 72'(strobeN), 72'(1));
    checkOutput("rst_rw", 72'(busRw), 72'(0));
    checkOutput("rst_wdata", 72'(busWdata), 72'(0));
    checkOutput("rst_win_data", winData, 72'(0));
    checkOutput("rst_win_valid", 72'(winValid), 72'(0));
    checkOutput("rst_ready", 72'(pixReady), 72'(0));
    checkOutput("rst_busy", 72'(busy), 72'(0));
    checkOutput("rst_done", 72'(done), 72'(0));
    resetN = 1'b1;
    tick();
    checkOutput("idle_busy", 72'(busy), 72'(0));

    // Frame 1: continuous source, backpressure on first window
    pulseStart();
    checkOutput("start_busy", 72'(busy), 72'(1));
    checkOutput("start_ready", 72'(pixReady), 72'(1));
    applyStimulus(1'b0, 12, cycles);
    checkOutput("wr_cycles", 72'(cycles), 72'(23));
    winReady = 1'b0;
    n = 0;
    while (rdStrobes - rdBase < 1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("wr_strobes", 72'(wrStrobes - frameBase), 72'(12));
    checkOutput("rd_strobe_1", 72'(rdStrobes - rdBase), 72'(1));
    checkOutput("rd_rw", 72'(busRw), 72'(1));
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("wdata_%0d", i), 72'(mem[i]), 72'(i + 1));
    end
    tick();
    checkOutput("lat_cap_valid", 72'(winValid), 72'(0));
    tick();
    checkOutput("lat_out_valid", 72'(winValid), 72'(1));
    checkOutput("win0_data", winData, W0);
`ifdef SOBEL_DRV_COORD_EN
    checkOutput("win0_row", 72'(winRow), 72'(0));
    checkOutput("win0_col", 72'(winCol), 72'(0));
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_valid", 72'(winValid), 72'(1));
      checkOutput("bp_data", winData, W0);
    end
    checkOutput("bp_strobes", 72'(rdStrobes - rdBase), 72'(1));
    checkOutput("bp_done", 72'(done), 72'(0));
    winReady = 1'b1;
    tick();
    checkOutput("b2b_valid_stb", 72'(winValid), 72'(0));
    checkOutput("b2b_strobe", 72'(strobeN), 72'(0));
    tick();
    checkOutput("b2b_valid_cap", 72'(winValid), 72'(0));
    tick();
    checkOutput("win1_valid", 72'(winValid), 72'(1));
    checkOutput("win1_data", winData, W1);
`ifdef SOBEL_DRV_COORD_EN
    checkOutput("win1_row", 72'(winRow), 72'(0));
    checkOutput("win1_col", 72'(winCol), 72'(1));
`endif
    checkOutput("rd_strobes", 72'(rdStrobes - rdBase), 72'(2));
    // start during the final handshake must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("fin_done", 72'(done), 72'(1));
    checkOutput("fin_busy", 72'(busy), 72'(0));
    checkOutput("fin_rw", 72'(busRw), 72'(0));
    checkOutput("fin_valid", 72'(winValid), 72'(0));
    tick();
    checkOutput("fin_ready", 72'(pixReady), 72'(0));
    checkOutput("fin_done_hold", 72'(done), 72'(1));
    checkOutput("fin_no_extra_rd", 72'(rdStrobes - rdBase), 72'(2));

    // Frame 2: stalling source
    frameBase = wrStrobes;
    rdBase    = rdStrobes;
    pulseStart();
    checkOutput("f2_done_clr", 72'(done), 72'(0));
    checkOutput("f2_busy", 72'(busy), 72'(1));
    applyStimulus(1'b1, 12, cycles);
    waitDone("f2_done");
    checkOutput("f2_wr_strobes", 72'(wrStrobes - frameBase), 72'(12));
    checkOutput("f2_rd_strobes", 72'(rdStrobes - rdBase), 72'(2));
    checkOutput("f2_win_data", winData, W1);

    // Frame 3: reset after five writes, then a full restart
    frameBase = wrStrobes;
    rdBase    = rdStrobes;
    pulseStart();
    applyStimulus(1'b0, 5, cycles);
    #2;
    checkOutput("pre_rst_strobe", 72'(strobeN), 72'(0));
    resetN = 1'b0;
    #1;
    checkOutput("mid_rst_strobe", 72'(strobeN), 72'(1));
    checkOutput("mid_rst_busy", 72'(busy), 72'(0));
    checkOutput("mid_rst_ready", 72'(pixReady), 72'(0));
    checkOutput("mid_rst_wdata", 72'(busWdata), 72'(0));
    checkOutput("mid_rst_win_data", winData, 72'(0));
    repeat (2) tick();
    resetN = 1'b1;
    tick();
    frameBase = wrStrobes;
    rdBase    = rdStrobes;
    pulseStart();
    applyStimulus(1'b0, 12, cycles);
    checkOutput("f3_wr_cycles", 72'(cycles), 72'(23));
    waitValid("f3_win0_valid");
    checkOutput("f3_win0_data", winData, W0);
`ifdef SOBEL_DRV_COORD_EN
    checkOutput("f3_win0_row", 72'(winRow), 72'(0));
    checkOutput("f3_win0_col", 72'(winCol), 72'(0));
`endif
    tick();
    waitValid("f3_win1_valid");
    checkOutput("f3_win1_data", winData, W1);
`ifdef SOBEL_DRV_COORD_EN
    checkOutput("f3_win1_row", 72'(winRow), 72'(0));
    checkOutput("f3_win1_col", 72'(winCol), 72'(1));
`endif
    waitDone("f3_done");
    checkOutput("f3_wr_strobes", 72'(wrStrobes - frameBase), 72'(12));
    checkOutput("f3_rd_strobes", 72'(rdStrobes - rdBase), 72'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
